// File: rtl/bp_be_pkg.sv
// Shared backend types for the D$ cache-service request arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_be_pkg;

    localparam int bp_be_cache_arb_num_req_gp = 2;

    typedef enum logic [1:0] {
        e_arb_idle,
        e_arb_send,
        e_arb_meta,
        e_arb_busy
    } bp_be_cache_arb_state_e;

endpackage

// File: rtl/bp_be_cache_arb_pick.sv
// Two-way request picker returning a one-hot grant (fixed priority or round-robin).
// Latency: purely combinational.
// Backpressure: none; grant is only a subset of req_v.
module bp_be_cache_arb_pick
    import bp_be_pkg::*;
(
    input  logic [bp_be_cache_arb_num_req_gp-1:0] req_v,
    input  logic                                  last_grant,
    input  logic                                  rr_en,
    output logic [bp_be_cache_arb_num_req_gp-1:0] grant
);

    always_comb begin
        grant = req_v;
        // Only a contention case needs a decision; a lone requester always wins.
        if (req_v == 2'b11) begin
            grant = (rr_en && !last_grant) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/bp_be_cache_req_arbiter.sv
// Shares the D$ LCE service channel between miss path (0) and PTW/uncached path (1); BP_BE_CACHE_ARB_RR_EN selects round-robin.
// Latency: accept in N -> cache_req_v_o in N+1; complete in M -> next accept no earlier than M+1.
// Backpressure: one transaction outstanding; losers and late arrivals see req_ready_o=0 and must hold req_v_i.
module bp_be_cache_req_arbiter
    import bp_be_pkg::*;
#(
    parameter int req_width_p      = 96,
    parameter int metadata_width_p = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [2*req_width_p-1:0]      req_i,
    input  logic [1:0]                    req_v_i,
    output logic [1:0]                    req_ready_o,
    input  logic [2*metadata_width_p-1:0] metadata_i,
    input  logic [1:0]                    metadata_v_i,
    output logic [1:0]                    critical_o,
    output logic [1:0]                    complete_o,
    output logic [req_width_p-1:0]        cache_req_o,
    output logic                          cache_req_v_o,
    input  logic                          cache_req_ready_i,
    output logic [metadata_width_p-1:0]   cache_req_metadata_o,
    output logic                          cache_req_metadata_v_o,
    input  logic                          cache_req_critical_i,
    input  logic                          cache_req_complete_i,
    output logic                          owner_o,
    output logic                          busy_o
);

    bp_be_cache_arb_state_e state_q, state_d;

    logic [req_width_p-1:0]      cache_req_q;
    logic [metadata_width_p-1:0] meta_q;
    logic                        meta_vld;
    logic                        owner_q;
    logic                        last_grant;
    logic                        rr_en;
    logic [1:0]                  grant;
    logic                        accept;
    logic                        meta_capture;
    logic [req_width_p-1:0]      win_req;
    logic [metadata_width_p-1:0] owner_meta;

`ifdef BP_BE_CACHE_ARB_RR_EN
    assign rr_en = 1'b1;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant[1];
        end
    end
`else
    assign rr_en      = 1'b0;
    assign last_grant = 1'b0;
`endif

    bp_be_cache_arb_pick u_pick (
        .req_v      (req_v_i),
        .last_grant (last_grant),
        .rr_en      (rr_en),
        .grant      (grant)
    );

    assign req_ready_o  = (state_q == e_arb_idle) ? grant : 2'b00;
    assign accept       = |(req_v_i & req_ready_o);
    assign win_req      = grant[1] ? req_i[req_width_p +: req_width_p] : req_i[0 +: req_width_p];
    assign owner_meta   = owner_q ? metadata_i[metadata_width_p +: metadata_width_p]
                                  : metadata_i[0 +: metadata_width_p];
    assign meta_capture = ((state_q == e_arb_send) || (state_q == e_arb_meta))
                          && metadata_v_i[owner_q];

    always_comb begin
        state_d                = state_q;
        cache_req_v_o          = 1'b0;
        cache_req_metadata_v_o = 1'b0;
        critical_o             = 2'b00;
        complete_o             = 2'b00;
        unique case (state_q)
            e_arb_idle: begin
                if (accept) state_d = e_arb_send;
            end
            e_arb_send: begin
                cache_req_v_o = 1'b1;
                if (cache_req_ready_i) state_d = e_arb_meta;
            end
            e_arb_meta: begin
                critical_o[owner_q] = cache_req_critical_i;
                complete_o[owner_q] = cache_req_complete_i;
                // An early complete wins over any metadata still waiting to go out.
                if (cache_req_complete_i) begin
                    state_d = e_arb_idle;
                end else if (meta_vld) begin
                    cache_req_metadata_v_o = 1'b1;
                    state_d                = e_arb_busy;
                end
            end
            e_arb_busy: begin
                critical_o[owner_q] = cache_req_critical_i;
                complete_o[owner_q] = cache_req_complete_i;
                if (cache_req_complete_i) state_d = e_arb_idle;
            end
            default: state_d = e_arb_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= e_arb_idle;
            cache_req_q <= '0;
            meta_q      <= '0;
            meta_vld    <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cache_req_q <= win_req;
                owner_q     <= grant[1];
                meta_vld    <= 1'b0;
            end
            if (meta_capture) begin
                meta_q   <= owner_meta;
                meta_vld <= 1'b1;
            end
        end
    end

    assign cache_req_o          = cache_req_q;
    assign cache_req_metadata_o = meta_q;
    assign owner_o              = owner_q;
    assign busy_o               = (state_q != e_arb_idle);

endmodule

// File: doc/bp_be_cache_req_arbiter.md
Name: bp_be_cache_req_arbiter

Overview:
- Shares the single D$-LCE cache service request channel (request, metadata, critical, complete) between two backend requesters.
- Requester 0 is the dcache miss path; requester 1 is the page-table walker / uncached path.
- Sits between the calculator's memory pipe and the LCE.
- Grants one requester per transaction, registers its request, and sequences the request and metadata phases to the LCE. Ownership is held until the LCE signals complete.

Parameters:
req_width_p, 96, width of one cache service request packet
metadata_width_p, 8, width of one request metadata packet (hit way, dirty)

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_n_i  in  1  asynchronous, active-low reset
req_i  in  2*req_width_p  per-requester request packets; slot k at [k*req_width_p +: req_width_p]
req_v_i  in  2  per-requester request valid
req_ready_o  out  2  per-requester ready; accept when req_v_i[k] & req_ready_o[k]
metadata_i  in  2*metadata_width_p  per-requester metadata packets
metadata_v_i  in  2  per-requester metadata valid (single-cycle pulse)
critical_o  out  2  critical-word pulse routed to the owner
complete_o  out  2  completion pulse routed to the owner
cache_req_o  out  req_width_p  registered request to the LCE
cache_req_v_o  out  1  request valid to the LCE
cache_req_ready_i  in  1  LCE ready; handshake is cache_req_v_o & cache_req_ready_i
cache_req_metadata_o  out  metadata_width_p  registered metadata to the LCE
cache_req_metadata_v_o  out  1  metadata valid to the LCE
cache_req_critical_i  in  1  critical data returned by the LCE
cache_req_complete_i  in  1  transaction complete from the LCE
owner_o  out  1  id of the current owner; valid when busy_o
busy_o  out  1  high in every state except IDLE

Behaviour:
- Interface: single clock clk_i; reset_n_i is asynchronous and active-low.
- Reset values: state=IDLE; req_ready_o=0; cache_req_v_o=0; cache_req_metadata_v_o=0; critical_o=0; complete_o=0; busy_o=0; owner_o=0; cache_req_o=0; cache_req_metadata_o=0; meta_vld=0; last_grant=1.
- Reset assertion mid-transaction returns to IDLE immediately. Any held request or metadata is dropped; no complete_o is issued.
- States:
  - IDLE: req_ready_o is asserted only to the arbitration winner among req_v_i, and only when req_v_i is high (req_ready_o depends on req_v_i; no ready for non-requesting slots). On accept: latch req_i slot into cache_req_o, set owner, clear meta_vld, go to SEND.
  - SEND: cache_req_v_o=1 and is held stable until cache_req_ready_i. On handshake go to META.
  - META: when meta_vld is set, assert cache_req_metadata_v_o for exactly one cycle, then go to BUSY.
  - BUSY: wait for cache_req_complete_i. On complete, pulse complete_o[owner] in the same cycle and go to IDLE.
- Metadata capture:
  - metadata_v_i[owner] in SEND or META latches metadata_i[owner] and sets meta_vld.
  - Metadata from the non-owner is ignored.
  - A second owner pulse before the forward overwrites the register (last wins).
- Routing: critical_o[owner]=cache_req_critical_i and complete_o[owner]=cache_req_complete_i, combinational, in META/BUSY only; both are 0 in IDLE/SEND.
- Early complete: cache_req_complete_i in META completes the transaction and returns to IDLE; pending metadata is dropped and metadata_v is not sent.
- Latency:
  - Request accepted in cycle N → cache_req_v_o high in N+1 (minimum).
  - Complete in cycle M → earliest next accept in M+1 (one-cycle bubble, no same-cycle re-grant).
- Fairness: only one transaction is outstanding at a time. Requests arriving while busy wait with req_ready_o=0 and must hold req_v_i.

Optional Feature:
- Macro: BP_BE_CACHE_ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous requests, the winner is the requester that is not last_grant; last_grant updates on every accept.
- Undefined: fixed priority, requester 0 always wins. last_grant is not implemented.

Decomposition:
- bp_be_pkg gains the enum bp_be_cache_arb_state_e {e_arb_idle, e_arb_send, e_arb_meta, e_arb_busy} and the localparam bp_be_cache_arb_num_req_gp=2.
- One sub-module: bp_be_cache_arb_pick, a combinational 2-way picker taking req_v, last_grant and the RR enable, returning a one-hot grant.

Test Plan:
- Single request: req_v_i=2'b01, cache_req_ready_i=1 → req_ready_o=2'b01 in cycle 0; cache_req_v_o=1 in cycle 1.
- Metadata then complete: metadata_v_i[0] pulsed in cycle 2; complete in cycle 6 → cache_req_metadata_v_o=1 for exactly one cycle; complete_o=2'b01 in cycle 6; busy_o=0 in cycle 7.
- Simultaneous requests: req_v_i=2'b11 held for three transactions → with RR_EN grants are 0,1,0; without it 0,0,0.
- Backpressure: cache_req_ready_i=0 for 5 cycles → cache_req_o stable and cache_req_v_o=1 throughout; no second req_ready_o.
- Early complete: complete asserted in META before metadata arrives → IDLE next cycle; cache_req_metadata_v_o never asserted.
- Reset mid-transaction: reset_n_i=0 while in BUSY with owner=1 → all outputs 0 asynchronously; after release, req_v_i=2'b10 is granted normally.
